kernel_sysid_checker: RTL and testbench

Sequencer and arbiter in front of the kernel system-ID slave. After reset it autonomously reads the ID word (address 0) and the timestamp word (address 1), compares both against build-time constants and reports pass/fail. It then hands the slave to the CPU data master. It sits between the Avalon interconnect and the combinational sysid slave, and gives software and board logic a hardware-verified "correct bitstream" flag.

---
 rtl/kernel_sysid_checker.sv | 130 +++++++++++++
 tb/tb_kernel_sysid_checker.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/kernel_sysid_checker.sv
// Sequencer/arbiter in front of the sysid slave: checks ID and timestamp after reset, then serves CPU reads.
// Optional periodic re-check is enabled by defining KERNEL_SYSID_RECHECK_EN.
module kernel_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID    = 32'd0,
    parameter logic [31:0] EXPECTED_TS    = 32'd1483522577,
    parameter logic [23:0] RECHECK_PERIOD = 24'd10_000_000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        s_address,
    input  logic        s_read,
    output logic        s_waitrequest,
    output logic [31:0] s_readdata,
    output logic        s_readdatavalid,
    output logic        sysid_address,
    input  logic [31:0] sysid_readdata,
    output logic        check_done,
    output logic        check_ok,
    output logic        mismatch_sticky
);

    localparam logic [1:0] CHK_ID = 2'd0;
    localparam logic [1:0] CHK_TS = 2'd1;
    localparam logic [1:0] SERVE  = 2'd2;

    logic [1:0]  state_q, state_d;
    logic        id_ok_q, id_ok_d;
    logic        check_done_q, check_done_d;
    logic        check_ok_q, check_ok_d;
    logic        sticky_q, sticky_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rvalid_q, rvalid_d;
    logic        check_pass;
`ifdef KERNEL_SYSID_RECHECK_EN
    logic [23:0] cnt_q, cnt_d;
`endif

    assign check_pass = id_ok_q & (sysid_readdata == EXPECTED_TS);

    always_comb begin
        state_d      = state_q;
        id_ok_d      = id_ok_q;
        check_done_d = check_done_q;
        check_ok_d   = check_ok_q;
        sticky_d     = sticky_q;
        rdata_d      = rdata_q;
        rvalid_d     = 1'b0;
`ifdef KERNEL_SYSID_RECHECK_EN
        cnt_d        = cnt_q;
`endif
        case (state_q)
            CHK_ID: begin
                id_ok_d = (sysid_readdata == EXPECTED_ID);
                state_d = CHK_TS;
            end
            CHK_TS: begin
                check_done_d = 1'b1;
                check_ok_d   = check_pass;
                sticky_d     = sticky_q | ~check_pass;
                state_d      = SERVE;
`ifdef KERNEL_SYSID_RECHECK_EN
                cnt_d        = RECHECK_PERIOD - 24'd1;
`endif
            end
            SERVE: begin
                if (s_read) begin
                    rdata_d  = sysid_readdata;
                    rvalid_d = 1'b1;
                end
`ifdef KERNEL_SYSID_RECHECK_EN
                // An expiry colliding with a CPU read is deferred until a read-free cycle.
                if (cnt_q == 24'd0) begin
                    if (!s_read) begin
                        state_d = CHK_ID;
                    end
                end else begin
                    cnt_d = cnt_q - 24'd1;
                end
`endif
            end
            default: state_d = CHK_ID;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= CHK_ID;
            id_ok_q      <= 1'b0;
            check_done_q <= 1'b0;
            check_ok_q   <= 1'b0;
            sticky_q     <= 1'b0;
            rdata_q      <= 32'd0;
            rvalid_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            id_ok_q      <= id_ok_d;
            check_done_q <= check_done_d;
            check_ok_q   <= check_ok_d;
            sticky_q     <= sticky_d;
            rdata_q      <= rdata_d;
            rvalid_q     <= rvalid_d;
        end
    end

`ifdef KERNEL_SYSID_RECHECK_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= 24'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    always_comb begin
        case (state_q)
            CHK_ID:  sysid_address = 1'b0;
            CHK_TS:  sysid_address = 1'b1;
            default: sysid_address = s_address;
        endcase
    end

    assign s_waitrequest   = (state_q != SERVE);
    assign s_readdata      = rdata_q;
    assign s_readdatavalid = rvalid_q;
    assign check_done      = check_done_q;
    assign check_ok        = check_ok_q;
    assign mismatch_sticky = sticky_q;

endmodule

// File: tb/tb_kernel_sysid_checker.sv
// Scoreboard bench for kernel_sysid_checker: random CPU reads and sysid corruption against a reference model.
// Re-check behaviour is exercised when KERNEL_SYSID_RECHECK_EN is defined.
module tb_kernel_sysid_checker;

    localparam logic [31:0] EXP_ID = 32'd0;
    localparam logic [31:0] EXP_TS = 32'd1483522577;
    localparam int          PERIOD = 8;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        s_address;
    logic        s_read;
    logic        s_waitrequest;
    logic [31:0] s_readdata;
    logic        s_readdatavalid;
    logic        sysid_address;
    logic [31:0] sysid_readdata;
    logic        check_done;
    logic        check_ok;
    logic        mismatch_sticky;
    logic [31:0] mem0, mem1;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    // Behavioural sysid slave: pure lookup.
    assign sysid_readdata = sysid_address ? mem1 : mem0;

    kernel_sysid_checker #(
        .EXPECTED_ID   (EXP_ID),
        .EXPECTED_TS   (EXP_TS),
        .RECHECK_PERIOD(24'd8)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .s_address      (s_address),
        .s_read         (s_read),
        .s_waitrequest  (s_waitrequest),
        .s_readdata     (s_readdata),
        .s_readdatavalid(s_readdatavalid),
        .sysid_address  (sysid_address),
        .sysid_readdata (sysid_readdata),
        .check_done     (check_done),
        .check_ok       (check_ok),
        .mismatch_sticky(mismatch_sticky)
    );

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;
    exp_t sbq[$];

    // Reference model: phase 0 = reading ID, 1 = reading timestamp, 2 = serving CPU.
    int m_phase;
    int m_serve;
    int cyc;
    bit m_id_ok, m_done, m_ok, m_sticky, m_good;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_phase  = 0;
            m_serve  = 0;
            cyc      = 0;
            m_id_ok  = 0;
            m_done   = 0;
            m_ok     = 0;
            m_sticky = 0;
            sbq.delete();
        end else begin
            if (m_phase == 0) begin
                m_id_ok = (mem0 == EXP_ID);
                m_phase = 1;
            end else if (m_phase == 1) begin
                m_good = m_id_ok && (mem1 == EXP_TS);
                m_done = 1;
                m_ok   = m_good;
                if (!m_good) m_sticky = 1;
                m_phase = 2;
                m_serve = 0;
            end else begin
                if (s_read) sbq.push_back('{(s_address ? mem1 : mem0), cyc + 1});
`ifdef KERNEL_SYSID_RECHECK_EN
                // Cycle number PERIOD-1 of serving is the last; a read there postpones the re-check.
                if (m_serve >= PERIOD - 1) begin
                    if (!s_read) m_phase = 0;
                end else begin
                    m_serve++;
                end
`endif
            end
            cyc++;
        end
    end

    // Monitor: samples on the falling edge.
    logic [31:0] last_data = 32'd0;
    exp_t        e;

    always @(negedge clock) begin
        if (!reset_n) begin
            chk("rst_rvalid", {31'd0, s_readdatavalid}, 32'd0);
            chk("rst_waitreq", {31'd0, s_waitrequest}, 32'd1);
            chk("rst_done", {31'd0, check_done}, 32'd0);
            chk("rst_ok", {31'd0, check_ok}, 32'd0);
            chk("rst_sticky", {31'd0, mismatch_sticky}, 32'd0);
            chk("rst_rdata", s_readdata, 32'd0);
            chk("rst_addr", {31'd0, sysid_address}, 32'd0);
            last_data = 32'd0;
        end else begin
            chk("waitreq", {31'd0, s_waitrequest}, {31'd0, m_phase != 2});
            chk("sysid_addr", {31'd0, sysid_address},
                (m_phase == 0) ? 32'd0 : (m_phase == 1) ? 32'd1 : {31'd0, s_address});
            chk("done", {31'd0, check_done}, {31'd0, m_done});
            chk("ok", {31'd0, check_ok}, {31'd0, m_ok});
            chk("sticky", {31'd0, mismatch_sticky}, {31'd0, m_sticky});
            if (s_readdatavalid) begin
                if (sbq.size() == 0) begin
                    chk("spurious_valid", 32'd1, 32'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("rdata", s_readdata, e.data);
                    chk("latency", cyc, e.due);
                    last_data = e.data;
                end
            end else if (sbq.size() > 0 && sbq[0].due <= cyc) begin
                chk("missing_valid", 32'd0, 32'd1);
                void'(sbq.pop_front());
            end
            chk("rdata_hold", s_readdata, last_data);
        end
    end

    task automatic step(input bit rd, input bit a);
        @(posedge clock);
        #2;
        s_read    = rd;
        s_address = a;
    endtask

    task automatic rand_steps(input int n, input bit corrupt_en);
        for (int i = 0; i < n; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if (corrupt_en && $urandom_range(0, 9) == 0)
                mem0 = ($urandom_range(0, 1) == 0) ? EXP_ID : $urandom;
        end
    endtask

    // Assert reset right after a clock edge, check it bites at once, then release.
    task automatic do_reset(input bit rd0, input bit a0);
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        s_read  = 1'b0;
        #1;
        chk("async_rvalid", {31'd0, s_readdatavalid}, 32'd0);
        chk("async_done", {31'd0, check_done}, 32'd0);
        chk("async_sticky", {31'd0, mismatch_sticky}, 32'd0);
        repeat (2) @(posedge clock);
        #2;
        s_read    = rd0;
        s_address = a0;
        reset_n   = 1'b1;
    endtask

    initial begin
        reset_n   = 1'b0;
        s_read    = 1'b0;
        s_address = 1'b0;
        mem0      = EXP_ID;
        mem1      = EXP_TS;
        repeat (3) @(posedge clock);

        // Read pending from cycle 0; accepted cycle 2; then addresses 0,1 back-to-back.
        do_reset(1'b1, 1'b1);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        step(1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b0);

        // Bad timestamp: flags fail but reads still served.
        mem1 = 32'h1234_5678;
        do_reset(1'b0, 1'b0);
        rand_steps(30, 1'b0);

        // Reset in the cycle after an accepted read drops the pending valid.
        mem1 = EXP_TS;
        do_reset(1'b0, 1'b0);
        rand_steps(10, 1'b0);
        step(1'b1, 1'b1);
        do_reset(1'b0, 1'b0);
        rand_steps(10, 1'b0);

`ifdef KERNEL_SYSID_RECHECK_EN
        // Idle until the re-check, then corrupt the ID across a re-check and restore it.
        do_reset(1'b0, 1'b0);
        repeat (14) step(1'b0, 1'b0);
        mem0 = 32'hDEAD_BEEF;
        repeat (12) step(1'b0, 1'b0);
        mem0 = EXP_ID;
        repeat (12) step(1'b0, 1'b0);
        // Keep reading through expiry points.
        repeat (20) step(1'b1, 1'($urandom_range(0, 1)));
        rand_steps(30, 1'b0);
`endif

        for (int k = 0; k < 6; k++) begin
            mem0 = ($urandom_range(0, 2) == 0) ? $urandom : EXP_ID;
            mem1 = ($urandom_range(0, 2) == 0) ? $urandom : EXP_TS;
            do_reset(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            rand_steps(40, 1'b1);
        end

        repeat (3) step(1'b0, 1'b0);
        @(negedge clock);
        chk("sb_empty", sbq.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
